// File: rtl/completion_arbiter_pkg.sv
// completion_arbiter_pkg: shared completion entry type, source enumeration and default widths
package completion_arbiter_pkg;
  localparam int NUM_CPL_SRC = 3;
  localparam int CPL_IDX_W = 2;
  localparam int CPL_DATA_W = 32;
  typedef enum logic [1:0] {CPL_ALU, CPL_MUL, CPL_MEM} cpl_src_e;
  typedef struct packed {
    logic [CPL_IDX_W-1:0] rob_idx;
    logic [CPL_DATA_W-1:0] data;
    logic excp;
  } completion_t;
endpackage

// File: rtl/completion_fifo.sv
// completion_fifo: per-source completion queue with synchronous flush and occupancy count
module completion_fifo
  import completion_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter type entry_t = completion_t
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   din,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     not_full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  assign not_full = count < CW'(DEPTH);
  // entry storage needs no reset; occupancy is defined by pointers and count alone
  always_ff @(posedge clk_i)
    if (push && !flush) mem[wr_ptr] <= din;
  // pointer and count bookkeeping; flush empties the queue and drops any same-cycle push/pop
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/completion_arbiter.sv
// completion_arbiter: round-robin merge of per-unit completion queues onto the ROB port (COMPLETION_ARB_STATS_EN adds grant/stall counters)
module completion_arbiter
  import completion_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_CPL_SRC,
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_ENTRY_WIDTH = CPL_IDX_W,
  parameter int DATA_WIDTH = CPL_DATA_W
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic [NUM_SRC-1:0]                 src_valid_i,
  output logic [NUM_SRC-1:0]                 src_ready_o,
  input  logic [NUM_SRC*ROB_ENTRY_WIDTH-1:0] src_rob_idx_i,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]      src_data_i,
  input  logic [NUM_SRC-1:0]                 src_excp_i,
  output logic                               complete_valid_o,
  output logic [ROB_ENTRY_WIDTH-1:0]         complete_idx_o,
  output logic [DATA_WIDTH-1:0]              complete_data_o,
  output logic                               complete_excp_o
`ifdef COMPLETION_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0]              grant_cnt_o,
  output logic [NUM_SRC*32-1:0]              stall_cnt_o
`endif
);
  localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef struct packed {
    logic [ROB_ENTRY_WIDTH-1:0] rob_idx;
    logic [DATA_WIDTH-1:0] data;
    logic excp;
  } entry_t;
  entry_t head [NUM_SRC];
  logic [CW-1:0] count [NUM_SRC];
  logic [NUM_SRC-1:0] not_full, push, pop, nonempty;
  logic [SW-1:0] rr_q, gnt_idx;
  logic gnt_vld, fire;
  assign src_ready_o = not_full & {NUM_SRC{!flush_i && rst_i}};
  assign push = src_valid_i & src_ready_o;
  assign fire = gnt_vld && !flush_i;
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    assign nonempty[s] = count[s] != '0;
    assign pop[s] = fire && gnt_idx == SW'(s);
    completion_fifo #(.DEPTH(FIFO_DEPTH), .entry_t(entry_t)) u_fifo (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .flush(flush_i),
      .push(push[s]),
      .pop(pop[s]),
      .din({src_rob_idx_i[s*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH], src_data_i[s*DATA_WIDTH +: DATA_WIDTH], src_excp_i[s]}),
      .head(head[s]),
      .count(count[s]),
      .not_full(not_full[s])
    );
  end
  // round-robin search starting just after the last winner; lowest distance wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr_q;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (nonempty[SW'((int'(rr_q) + k) % NUM_SRC)]) begin
        gnt_vld = 1'b1;
        gnt_idx = SW'((int'(rr_q) + k) % NUM_SRC);
      end
    end
  end
  // registered completion port and round-robin pointer; flush squashes the grant
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      rr_q <= SW'(NUM_SRC - 1);
      complete_valid_o <= 1'b0;
      {complete_idx_o, complete_data_o, complete_excp_o} <= '0;
    end else begin
      complete_valid_o <= fire;
      {complete_idx_o, complete_data_o, complete_excp_o} <= fire ? head[gnt_idx] : '0;
      if (fire) rr_q <= gnt_idx;
    end
`ifdef COMPLETION_ARB_STATS_EN
  logic [31:0] grant_cnt [NUM_SRC];
  logic [31:0] stall_cnt [NUM_SRC];
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_stat
    assign grant_cnt_o[s*32 +: 32] = grant_cnt[s];
    assign stall_cnt_o[s*32 +: 32] = stall_cnt[s];
    // per-source grant and stall tallies, cleared only by reset and wrapping freely
    always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
        grant_cnt[s] <= '0;
        stall_cnt[s] <= '0;
      end else begin
        grant_cnt[s] <= grant_cnt[s] + 32'(pop[s]);
        stall_cnt[s] <= stall_cnt[s] + 32'(src_valid_i[s] && !src_ready_o[s]);
      end
  end
`endif
endmodule

// File: doc/completion_arbiter.md
Name: completion_arbiter

Overview:
Merges result completions from several execution units (ALU, MUL, MEM) onto the single completion port of the reorder buffer.
- Each source has a small per-source queue with a valid/ready handshake.
- A round-robin arbiter drains one queued completion per cycle into a registered output that drives the ROB's complete valid/idx/data/excp inputs.
- No back-pressure from the ROB; the ROB accepts one completion every cycle.

Parameters:
NUM_SRC, 3, number of execution-unit completion sources (index 0 = ALU, 1 = MUL, 2 = MEM)
FIFO_DEPTH, 2, entries per source queue (power of two, >= 2)
ROB_ENTRY_WIDTH, 2, width of ROB entry index
DATA_WIDTH, 32, result data width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous pipeline flush; discards all queued and pending completions
src_valid_i  in  NUM_SRC  per-source completion valid
src_ready_o  out  NUM_SRC  per-source queue can accept
src_rob_idx_i  in  NUM_SRC*ROB_ENTRY_WIDTH  per-source ROB index, source s at bits [s*W +: W]
src_data_i  in  NUM_SRC*DATA_WIDTH  per-source result data, same packing
src_excp_i  in  NUM_SRC  per-source exception flag
complete_valid_o  out  1  completion valid to ROB
complete_idx_o  out  ROB_ENTRY_WIDTH  ROB index being completed
complete_data_o  out  DATA_WIDTH  result data
complete_excp_o  out  1  exception flag

Behaviour:
- Reset (rst_i low, asynchronous):
  - All queues empty; all count/pointers 0.
  - rr_q = NUM_SRC-1, so source 0 has first priority.
  - complete_valid_o = 0; complete_idx_o, complete_data_o, complete_excp_o = 0.
  - src_ready_o = all ones once reset is released; forced 0 while rst_i is low.
- Accept: source s transfers on a rising edge where src_valid_i[s] & src_ready_o[s].
- src_ready_o[s] = (count[s] < FIFO_DEPTH) & !flush_i.
  - Registered-state only; no combinational path from the arbiter grant.
- Arbitration (combinational on registered queue state):
  - Search s = rr_q+1, rr_q+2, ... mod NUM_SRC; grant the first non-empty queue.
  - On grant: pop its head, rr_q <= granted index. With no grant, rr_q holds.
- Output register:
  - On grant, the next cycle has complete_valid_o=1 and idx/data/excp equal to the popped entry.
  - Otherwise complete_valid_o=0 and idx/data/excp = 0.
  - Output lasts exactly one cycle per completion; no duplicates, no drops.
- Latency: handshake at edge N -> queued from cycle N+1 -> earliest complete_valid_o in cycle N+2 (2 cycles). Throughput: 1 completion per cycle aggregate.
- Same-queue push and pop in one cycle: count unchanged, FIFO order preserved. Push into a full queue cannot occur because ready is 0.
- Pointer wrap: read/write pointers wrap modulo FIFO_DEPTH; count runs 0..FIFO_DEPTH.
- Flush:
  - All counts and pointers go to 0 on the next edge.
  - complete_valid_o = 0 in the following cycle.
  - Any push or grant in the flush cycle is discarded.
  - rr_q is unchanged.
- Reset mid-operation: all queued entries are lost immediately and outputs drop to reset values asynchronously.
- ROB index and data pass through unmodified; no arithmetic beyond pointer/count increments.

Optional Feature:
Macro COMPLETION_ARB_STATS_EN.
- When defined, adds two output ports:
  - grant_cnt_o, NUM_SRC*32: per-source count of granted completions.
  - stall_cnt_o, NUM_SRC*32: per-source count of cycles with src_valid_i & !src_ready_o.
- Counter behaviour:
  - Cleared by reset only, not by flush.
  - Wrap modulo 2^32.
  - Sampled every edge.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- params_pkg gains:
  - completion_t packed struct {rob_idx [ROB_ENTRY_WIDTH], data [DATA_WIDTH], excp}.
  - localparam NUM_CPL_SRC = 3, with enum cpl_src_e {CPL_ALU, CPL_MUL, CPL_MEM}.
- One natural sub-module: completion_fifo.
  - Parameterised FIFO_DEPTH and entry type.
  - Ports: push, pop, flush, head, count, not-full.
  - Instantiated NUM_SRC times.
- The arbiter and output register stay in completion_arbiter.

Test Plan:
- Single ALU completion idx=2 data=0xDEADBEEF excp=0 accepted at edge 1 -> complete_valid_o=1, idx=2, data=0xDEADBEEF at cycle 3; valid low otherwise.
- All three sources valid in the same cycle (idx 0,1,2) after reset -> outputs in order src0, src1, src2 on consecutive cycles; rr_q ends at 2.
- Source 1 pushes three back-to-back while sources 0 and 2 keep winning -> src_ready_o[1]=0 after 2 queued; third accepted only after a src1 grant; FIFO order preserved.
- MEM completion with excp=1 data=0x0 idx=3 -> complete_excp_o=1, idx=3 passed unchanged.
- Queues holding 4 total entries, flush_i pulsed -> no complete_valid_o from the following cycle; src_ready_o all 1 after flush; a new push completes with 2-cycle latency.
- rst_i dropped asynchronously mid-burst -> complete_valid_o=0 immediately; after release, first valid source 0 granted first.
- With COMPLETION_ARB_STATS_EN: repeat scenario 3 -> grant_cnt_o[1]=3, stall_cnt_o[1] equals the number of stalled cycles.
